// File: rtl/quad_snapshot_ctrl.sv
// Sampling scheduler for a bank of quadrature encoder counters.
// On each tick it latches every channel at once and streams pos/delta beats, one channel per beat.
module quad_snapshot_ctrl #(
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 24
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [32*CHANNELS-1:0]   count_in,
  input  logic [PERIOD_W-1:0]      period,
  input  logic                     snap_req,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [3:0]               out_chan,
  output logic [31:0]              out_pos,
  output logic [31:0]              out_delta,
  output logic                     out_last,
  output logic                     out_first,
  output logic                     overrun,
  input  logic                     overrun_clr
);

  localparam logic [3:0] LAST_CH = 4'(CHANNELS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] cnt;
  logic                tick_t, tick, hs;
  logic                capture, drop, first;
  logic [3:0]          ch_nx;
  logic [31:0]         cin       [CHANNELS];
  logic [31:0]         cap_delta [CHANNELS];
  logic [31:0]         snap      [CHANNELS];
  logic [31:0]         delta     [CHANNELS];
  logic [31:0]         sel_pos, sel_delta;

  assign tick_t = (period != '0) && (cnt == '0);
  assign tick   = tick_t || snap_req;
  assign hs     = (state == SEND) && out_ready;

  // A zero period freezes the countdown so re-enabling resumes from where it stopped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (period != '0) begin
      if (tick)
        cnt <= period - PERIOD_W'(1);
      else if (cnt != '0)
        cnt <= cnt - PERIOD_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = out_chan;
    capture  = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          capture  = 1'b1;
          state_nx = SEND;
          ch_nx    = '0;
        end
      end
      SEND: begin
        if (hs && (out_chan == LAST_CH)) begin
          ch_nx = '0;
          if (tick)
            capture = 1'b1;
          else
            state_nx = IDLE;
        end else begin
          if (hs)
            ch_nx = out_chan + 4'd1;
          drop = tick;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      cin[k]       = count_in[32*k +: 32];
      cap_delta[k] = first ? 32'd0 : cin[k] - snap[k];
    end
  end

  // Output mux looks ahead to the next channel so every output leaves a flop.
  always_comb begin
    sel_pos   = '0;
    sel_delta = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_nx == 4'(k)) begin
        sel_pos   = capture ? cin[k]       : snap[k];
        sel_delta = capture ? cap_delta[k] : delta[k];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      first <= 1'b1;
      for (int k = 0; k < CHANNELS; k++) begin
        snap[k]  <= '0;
        delta[k] <= '0;
      end
    end else begin
      state <= state_nx;
      if (capture) begin
        first <= 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          snap[k]  <= cin[k];
          delta[k] <= cap_delta[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_chan  <= '0;
      out_pos   <= '0;
      out_delta <= '0;
      out_last  <= 1'b0;
      out_first <= 1'b1;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state_nx == SEND);
      out_chan  <= ch_nx;
      out_pos   <= sel_pos;
      out_delta <= sel_delta;
      out_last  <= (state_nx == SEND) && (ch_nx == LAST_CH);
      if (capture)
        out_first <= first;
      overrun   <= drop | (overrun & ~overrun_clr);
    end
  end

endmodule

// File: tb/tb_quad_snapshot_ctrl.sv
// Randomized bench for quad_snapshot_ctrl checked against a beat-queue model of the sampler.
module tb_quad_snapshot_ctrl;

  localparam int CH = 4;
  localparam int PW = 24;

  logic            clk = 1'b0;
  logic            resetn;
  logic [32*CH-1:0] count_in;
  logic [PW-1:0]   period;
  logic            snap_req, out_ready, overrun_clr;
  logic            out_valid, out_last, out_first, overrun;
  logic [3:0]      out_chan;
  logic [31:0]     out_pos, out_delta;

  always #5 clk = ~clk;

  quad_snapshot_ctrl #(.CHANNELS(CH), .PERIOD_W(PW)) dut (
    .clk(clk), .resetn(resetn), .count_in(count_in), .period(period),
    .snap_req(snap_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_chan(out_chan), .out_pos(out_pos), .out_delta(out_delta),
    .out_last(out_last), .out_first(out_first), .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] pos;
    logic [31:0] dlt;
    logic        last;
    logic        first;
  } beat_t;

  beat_t       q[$];
  int          m_cnt;
  logic [31:0] m_prev [CH];
  bit          m_first;
  bit          m_ovr;

  task automatic model_reset();
    q.delete();
    m_cnt   = 0;
    m_first = 1'b1;
    m_ovr   = 1'b0;
    for (int k = 0; k < CH; k++) m_prev[k] = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit    tick, busy, hs, fin, drop;
    beat_t b;
    tick = ((period != 0) && (m_cnt == 0)) || snap_req;
    busy = (q.size() != 0);
    hs   = busy && out_ready;
    if (hs) b = q.pop_front();
    fin  = hs && (q.size() == 0);
    drop = tick && busy && !fin;
    if (tick && !drop) begin
      for (int k = 0; k < CH; k++) begin
        b.ch    = 4'(k);
        b.pos   = count_in[32*k +: 32];
        b.dlt   = m_first ? 32'd0 : b.pos - m_prev[k];
        b.last  = (k == CH - 1);
        b.first = m_first;
        q.push_back(b);
        m_prev[k] = b.pos;
      end
      m_first = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (overrun_clr) m_ovr = 1'b0;
    if (period != 0) begin
      if (tick) m_cnt = int'(period) - 1;
      else if (m_cnt != 0) m_cnt--;
    end
  endtask

  task automatic check_outputs();
    chk("valid", out_valid, q.size() != 0);
    chk("overrun", overrun, m_ovr);
    if (q.size() != 0) begin
      chk("chan", out_chan, q[0].ch);
      chk("pos", out_pos, q[0].pos);
      chk("delta", out_delta, q[0].dlt);
      chk("last", out_last, q[0].last);
      chk("first", out_first, q[0].first);
    end
  endtask

  task automatic cyc();
    check_outputs();
    model_edge();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_cnt(input int k, input logic [31:0] v);
    count_in[32*k +: 32] = v;
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    cyc();
    snap_req = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_first", out_first, 1'b1);
    chk("rst_overrun", overrun, 1'b0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn      = 1'b0;
    count_in    = '0;
    period      = '0;
    snap_req    = 1'b0;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_chan", out_chan, 4'd0);
    chk("reset_pos", out_pos, 32'd0);
    chk("reset_delta", out_delta, 32'd0);
    chk("reset_last", out_last, 1'b0);
    chk("reset_first", out_first, 1'b1);
    chk("reset_overrun", overrun, 1'b0);
    resetn = 1'b1;

    // cadence and signed deltas
    period = PW'(8);
    for (int k = 0; k < CH; k++) set_cnt(k, 32'(100 * (k + 1)));
    run(12);
    set_cnt(0, 32'd105); set_cnt(1, 32'd197); set_cnt(2, 32'd300); set_cnt(3, 32'd401);
    run(20);

    // wrap-around in both directions
    set_cnt(0, 32'hFFFF_FFFE); run(8);
    set_cnt(0, 32'h0000_0003); run(8);
    set_cnt(0, 32'hFFFF_FFFE); run(8);

    // back-to-back frames
    period = PW'(4);
    run(24);

    // overrun with stalled consumer, then drain and clear
    out_ready = 1'b0;
    run(20);
    out_ready = 1'b1;
    run(6);
    overrun_clr = 1'b1;
    cyc();
    overrun_clr = 1'b0;
    period = '0;
    run(10);

    // manual trigger only
    pulse_snap(); run(10);
    pulse_snap(); run(10);

    // snap request coincident with timer tick
    period = PW'(6);
    for (int i = 0; i < 20 && !(m_cnt == 0 && q.size() == 0); i++) cyc();
    pulse_snap();
    run(10);

    // reset during the ch2 beat
    period = PW'(8);
    begin
      bit found = 1'b0;
      for (int i = 0; i < 24; i++) begin
        if (q.size() != 0 && q[0].ch == 4'd2) begin
          found = 1'b1;
          break;
        end
        cyc();
      end
      chk("find_ch2", found, 1'b1);
    end
    do_reset();
    run(20);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) period = PW'($urandom_range(0, 10));
      out_ready   = ($urandom_range(0, 3) != 0);
      snap_req    = ($urandom_range(0, 11) == 0);
      overrun_clr = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < CH; k++) begin
        if ($urandom_range(0, 7) == 0)
          set_cnt(k, $urandom);
        else
          set_cnt(k, count_in[32*k +: 32] + 32'($urandom_range(0, 40)) - 32'd20);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      cyc();
    end
    snap_req    = 1'b0;
    overrun_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
